// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_loader_pkg;

    // Loader frame-parsing states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Byte offsets of the fixed header fields within a frame; data bytes
    // follow the header, and the checksum byte follows the 4*N data bytes.
    localparam int OFS_SYNC   = 0;
    localparam int OFS_LEN_LO = 1;
    localparam int OFS_LEN_HI = 2;
    localparam int OFS_DATA   = 3;

    // Byte address of word number idx relative to base (32-bit wrap allowed)
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words (LSB lane first).
// Latency: word_cmp/word_dat are combinational on the cycle the 4th byte is offered.
// Backpressure: none; every byte_vld cycle consumes a byte.
module prog_loader_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_cmp,
    output logic [31:0] word_dat
);

    logic [1:0]  byte_idx;
    logic [23:0] lanes;

    // Track the lane position and hold the three low bytes of the word in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            lanes    <= 24'd0;
        end else if (clr) begin
            byte_idx <= 2'd0;
            lanes    <= 24'd0;
        end else if (byte_vld) begin
            case (byte_idx)
                2'd0:    lanes[7:0]   <= byte_dat;
                2'd1:    lanes[15:8]  <= byte_dat;
                2'd2:    lanes[23:16] <= byte_dat;
                default: lanes        <= lanes;
            endcase
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // The top byte is never stored: the full word is formed while it is on the bus
    assign word_cmp = byte_vld && (byte_idx == 2'd3);
    assign word_dat = {byte_dat, lanes};

endmodule

// File: rtl/prog_loader.sv
// Parses a sync/length/data/checksum frame from the UART and writes words to imem.
// Latency: imem write strobe one cycle after a word's 4th byte; done one cycle after CHK.
// Backpressure: none; bytes arrive as strobes and are consumed or ignored immediately.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int          TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t        state;
    logic [15:0]   len;
    logic [7:0]    chk;
    logic [TW-1:0] timer;

    logic          in_frame;
    logic          sync_hit;
    logic          timeout_hit;
    logic          restart;
    logic [15:0]   len_full;
    logic          wa_vld;
    logic          word_cmp;
    logic [31:0]   word_dat;

    assign in_frame    = (state == S_LEN0) || (state == S_LEN1) ||
                         (state == S_DATA) || (state == S_CHECK);
    assign sync_hit    = rx_valid && (rx_data == SYNC_BYTE);
    // A byte on the same cycle as the last idle tick still counts as on time
    assign timeout_hit = in_frame && !rx_valid && (timer == TMR_LAST);
    assign restart     = sync_hit && ((state == S_IDLE) || (state == S_ERR));
    assign len_full    = {rx_data, len[7:0]};
    assign wa_vld      = rx_valid && (state == S_DATA);

    prog_loader_word_assembler u_word_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (restart),
        .byte_vld (wa_vld),
        .byte_dat (rx_data),
        .word_cmp (word_cmp),
        .word_dat (word_dat)
    );

    // Inter-byte idle timer: runs only inside a frame, restarts on every byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!in_frame || rx_valid) begin
            timer <= '0;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Frame FSM with registered outputs, checksum and write-address generation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            len          <= 16'd0;
            chk          <= 8'd0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_rst      <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (timeout_hit) begin
                state   <= S_ERR;
                error   <= 1'b1;
                cpu_rst <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (restart) begin
                            state        <= S_LEN0;
                            error        <= 1'b0;
                            words_loaded <= 16'd0;
                            chk          <= 8'd0;
                        end
                    end
                    S_LEN0: begin
                        if (rx_valid) begin
                            len[7:0] <= rx_data;
                            state    <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (rx_valid) begin
                            len[15:8] <= rx_data;
                            if ({16'd0, len_full} > DEPTH_W) begin
                                state   <= S_ERR;
                                error   <= 1'b1;
                                cpu_rst <= 1'b1;
                            end else if (len_full == 16'd0) begin
                                state <= S_CHECK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (rx_valid) begin
                            chk <= chk + rx_data;
                            if (word_cmp) begin
                                imem_we      <= 1'b1;
                                imem_addr    <= word_byte_addr(BASE_ADDR, words_loaded);
                                imem_wdata   <= word_dat;
                                words_loaded <= words_loaded + 16'd1;
                                if ((words_loaded + 16'd1) == len) begin
                                    state <= S_CHECK;
                                end
                            end
                        end
                    end
                    S_CHECK: begin
                        if (rx_valid) begin
                            if (rx_data == chk) begin
                                state   <= S_DONE;
                                done    <= 1'b1;
                                cpu_rst <= 1'b0;
                            end else begin
                                state   <= S_ERR;
                                error   <= 1'b1;
                                cpu_rst <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state   <= S_ERR;
                        error   <= 1'b1;
                        cpu_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame scenarios with a write scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_prog_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int          vectors;
    int          miscompares;
    int          wr_count;
    logic [63:0] exp_q[$];
    byte_q_t     seq;

    prog_loader #(
        .DEPTH     (64),
        .BASE_ADDR (32'h0000_0000),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [63:0] e;
            wr_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    miscompares++;
                    $display("FAIL write addr/data got %h/%h want %h/%h", imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        wr_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #3;
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded} !==
            {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_state we=%b addr=%h wdata=%h cpu_rst=%b done=%b error=%b words=%0d want 0/0/0/1/0/0/0",
                     imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded);
        end
        apply_reset();
    endtask

    task automatic good_image_body(input string tag);
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00};
        send_seq(seq);
        vectors++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_before_chk done=%b cpu_rst=%b want 0/1", tag, done, cpu_rst);
        end
        send_byte(8'hB6);
        vectors++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd2) begin
            miscompares++;
            $display("FAIL %s_done done=%b cpu_rst=%b error=%b words=%0d want 1/0/0/2",
                     tag, done, cpu_rst, error, words_loaded);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || wr_count != 2) begin
            miscompares++;
            $display("FAIL %s_writes pending=%0d seen=%0d want 0/2", tag, exp_q.size(), wr_count);
        end
    endtask

    task automatic test_good_image();
        apply_reset();
        good_image_body("good_image");
        // Bytes after DONE must be ignored
        seq = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_seq(seq);
        vectors++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 16'd2 || wr_count != 2) begin
            miscompares++;
            $display("FAIL done_sticky done=%b cpu_rst=%b words=%0d writes=%0d want 1/0/2/2",
                     done, cpu_rst, words_loaded, wr_count);
        end
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        exp_q.push_back({32'h0000_0004, 32'h0010_0093});
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        send_seq(seq);
        vectors++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bad_checksum error=%b cpu_rst=%b done=%b pending=%0d want 1/1/0/0",
                     error, cpu_rst, done, exp_q.size());
        end
    endtask

    task automatic test_oversize();
        apply_reset();
        seq = '{8'hA5, 8'h41};
        send_seq(seq);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize_early error=%b want 0", error);
        end
        send_byte(8'h00);
        vectors++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL oversize error=%b cpu_rst=%b done=%b want 1/1/0", error, cpu_rst, done);
        end
        seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_seq(seq);
        vectors++;
        if (wr_count != 0 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL oversize_no_write writes=%0d error=%b want 0/1", wr_count, error);
        end
    endtask

    task automatic test_zero_length();
        apply_reset();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(seq);
        vectors++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0 || words_loaded !== 16'd0 || wr_count != 0) begin
            miscompares++;
            $display("FAIL zero_length done=%b cpu_rst=%b error=%b words=%0d writes=%0d want 1/0/0/0/0",
                     done, cpu_rst, error, words_loaded, wr_count);
        end
    endtask

    task automatic test_timeout_recovery();
        apply_reset();
        seq = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00};
        send_seq(seq);
        repeat (999) @(posedge clk);
        #1;
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early error=%b at 999 idle cycles want 0", error);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (error !== 1'b1 || cpu_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout error=%b cpu_rst=%b at 1000 idle cycles want 1/1", error, cpu_rst);
        end
        send_byte(8'hA5);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL recovery_clear error=%b want 0", error);
        end
        exp_q.push_back({32'h0000_0000, 32'h0000_0013});
        seq = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_seq(seq);
        @(posedge clk);
        #1;
        vectors++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 16'd1 || exp_q.size() != 0 || wr_count != 1) begin
            miscompares++;
            $display("FAIL recovery done=%b cpu_rst=%b words=%0d pending=%0d writes=%0d want 1/0/1/0/1",
                     done, cpu_rst, words_loaded, exp_q.size(), wr_count);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00};
        send_seq(seq);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded} !==
            {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            miscompares++;
            $display("FAIL mid_load_reset we=%b addr=%h wdata=%h cpu_rst=%b done=%b error=%b words=%0d want 0/0/0/1/0/0/0",
                     imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded);
        end
        apply_reset();
        good_image_body("replay");
    endtask

    task automatic test_back_to_back_frames();
        // A bad frame followed immediately by a good one must recover cleanly
        apply_reset();
        seq = '{8'hA5, 8'h00, 8'h00, 8'h01};
        send_seq(seq);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_err error=%b want 1", error);
        end
        good_image_body("b2b");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_count    = 0;
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_timeout_recovery();
        test_reset_mid_load();
        test_back_to_back_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
